// File: rtl/cmp_cal_sequencer.sv
// cmp_cal_sequencer: shares one calibration DAC across a comparator bank, running a SAR
// threshold search per comparator and keeping the codes in a registered-read result file.
module cmp_cal_sequencer #(
    parameter int N_CMP      = 15,
    parameter int DAC_BITS   = 16,
    parameter int SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_CMP-1:0]    cmp_out,
    output logic [DAC_BITS-1:0] DAC_ctl,
    output logic [5:0]          cmp_sel,
    output logic [3:0]          b_left,
    output logic [3:0]          b_right,
    output logic                busy,
    output logic                done,
    output logic [N_CMP-1:0]    valid,
    input  logic [5:0]          rd_addr,
    output logic [DAC_BITS-1:0] rd_data
);
    typedef enum logic [2:0] {IDLE, LOAD, TRIAL, STORE, DONE} state_t;

    state_t              r_state, w_next;
    logic [DAC_BITS-1:0] r_dac, r_rd, w_rd, w_mask, w_sar;
    logic [DAC_BITS-1:0] r_result [N_CMP];
    logic [N_CMP-1:0]    r_valid;
    logic [5:0]          r_cmp_sel;
    logic [3:0]          r_bit_idx, r_settle;
    logic                r_busy, r_done;
    logic [63:0]         w_cmp_ext;
    logic                w_cmp_bit, w_sample, w_last, w_abort;

    assign w_cmp_ext = 64'(cmp_out);
    assign w_cmp_bit = w_cmp_ext[r_cmp_sel];
    assign w_sample  = (r_state == TRIAL) && (r_settle == 4'(SETTLE_CYC));
    assign w_last    = r_cmp_sel == 6'(N_CMP - 1);
    assign w_abort   = abort && (r_state != IDLE);
    // Trial bit is dropped when the comparator trips; the next lower bit is always tried.
    assign w_mask    = DAC_BITS'(1) << r_bit_idx;
    assign w_sar     = (r_dac & ~(w_cmp_bit ? w_mask : '0)) | (w_mask >> 1);

    always_comb begin
        w_next = r_state;
        if (w_abort)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:    w_next = (start && !abort) ? LOAD : IDLE;
                LOAD:    w_next = TRIAL;
                TRIAL:   w_next = (w_sample && r_bit_idx == 4'd0) ? STORE : TRIAL;
                STORE:   w_next = w_last ? DONE : LOAD;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_CMP; i++)
            if (rd_addr == 6'(i)) w_rd = r_result[i];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dac     <= '0;
            r_cmp_sel <= '0;
            r_bit_idx <= '0;
            r_settle  <= '0;
            r_valid   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd      <= '0;
            for (int i = 0; i < N_CMP; i++) r_result[i] <= '0;
        end else begin
            r_busy <= (w_next == LOAD) || (w_next == TRIAL) || (w_next == STORE);
            r_done <= (r_state == DONE) && !abort;
            r_rd   <= w_rd;
            if (w_abort) begin
                r_dac     <= '0;
                r_cmp_sel <= '0;
            end else
                case (r_state)
                    IDLE:
                        if (w_next == LOAD) begin
                            r_cmp_sel <= '0;
                            r_valid   <= '0;
                        end
                    LOAD: begin
                        r_dac     <= DAC_BITS'(1) << (DAC_BITS - 1);
                        r_bit_idx <= 4'(DAC_BITS - 1);
                        r_settle  <= '0;
                    end
                    TRIAL:
                        if (w_sample) begin
                            r_dac     <= w_sar;
                            r_bit_idx <= r_bit_idx - 4'd1;
                            r_settle  <= '0;
                        end else
                            r_settle <= r_settle + 4'd1;
                    STORE: begin
                        for (int i = 0; i < N_CMP; i++)
                            if (r_cmp_sel == 6'(i)) r_result[i] <= r_dac;
                        r_valid <= r_valid | (N_CMP'(1) << r_cmp_sel);
                        if (!w_last) r_cmp_sel <= r_cmp_sel + 6'd1;
                    end
                    DONE: begin
                        r_dac     <= '0;
                        r_cmp_sel <= '0;
                    end
                    default: r_dac <= '0;
                endcase
        end
    end

    assign DAC_ctl = r_dac;
    assign cmp_sel = r_cmp_sel;
    assign busy    = r_busy;
    assign done    = r_done;
    assign valid   = r_valid;
    assign rd_data = r_rd;
    assign b_left  = {4{r_busy}};
    assign b_right = {4{r_busy}};
endmodule

// File: doc/cmp_cal_sequencer.md
# cmp_cal_sequencer

Synthesizable offset-calibration sequencer for the flash ADC comparator bank. It shares one DAC_BITS-wide calibration DAC across N_CMP comparators. For each comparator in turn it runs a binary (SAR) threshold search on the DAC code, then stores the resulting code in an internal result file. The result file is read back through a registered read port. The block sits between the calibration DAC, the comparator outputs and the trim/configuration logic.

## Interface
Parameters:
- N_CMP, 15, number of comparators calibrated (1..64)
- DAC_BITS, 16, calibration DAC width (2..16)
- SETTLE_CYC, 1, clock cycles allowed for DAC/comparator settling before each sample (0..15)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request to calibrate all comparators; ignored unless state is IDLE
- abort  input  1  stops calibration at any state; has priority over start
- cmp_out  input  N_CMP  comparator outputs, synchronous to clk; 1 = DAC above comparator threshold
- DAC_ctl  output  DAC_BITS  calibration DAC code (registered)
- cmp_sel  output  6  index of comparator under calibration (registered)
- b_left  output  4  left trim code: 4'b1111 while busy, 4'b0000 otherwise
- b_right  output  4  right trim code: 4'b1111 while busy, 4'b0000 otherwise
- busy  output  1  high from first LOAD through last STORE
- done  output  1  one-cycle pulse after the last comparator is stored
- valid  output  N_CMP  per-comparator result-valid flags
- rd_addr  input  6  result-file read address
- rd_data  output  DAC_BITS  result for rd_addr, one-cycle latency; 0 if rd_addr ≥ N_CMP

## Operation
- States: IDLE, LOAD, TRIAL, STORE, DONE.
- Reset values:
  - State is IDLE.
  - DAC_ctl, cmp_sel, valid, rd_data, busy and done are all 0.
  - b_left and b_right are 0.
  - Result file is cleared to 0.
- IDLE→LOAD on start:
  - cmp_sel←0.
  - All valid flags are cleared.
- LOAD (1 cycle):
  - DAC_ctl←1<<(DAC_BITS-1).
  - bit_idx←DAC_BITS-1.
  - settle counter←0.
  - Go to TRIAL.
- TRIAL:
  - Count SETTLE_CYC cycles, then sample cmp_out[cmp_sel] on the next edge.
  - If the sample is 1, clear DAC_ctl[bit_idx].
  - If bit_idx>0, set DAC_ctl[bit_idx-1], decrement bit_idx, restart the settle count and stay in TRIAL.
  - If bit_idx=0, go to STORE.
- STORE (1 cycle):
  - result[cmp_sel]←DAC_ctl and valid[cmp_sel]←1.
  - If cmp_sel=N_CMP-1, go to DONE; otherwise cmp_sel++ and go to LOAD.
- DONE (1 cycle):
  - done=1.
  - DAC_ctl←0 and cmp_sel←0.
  - Go to IDLE.
- Arithmetic: the SAR result is the largest code for which the comparator outputs 0, i.e. threshold−1. If cmp_out is always 1 the result is 0; if always 0 the result is all-ones.
- abort (any non-IDLE state):
  - Next state is IDLE; DAC_ctl←0 and cmp_sel←0.
  - The result of the in-progress comparator is not stored.
  - Already-set valid flags and stored results are kept.
  - done is not pulsed.
- Reset mid-operation behaves as full reset: the result file and valid flags are cleared.
- The read port is independent of the sequencer. A read of an entry in the same cycle as its STORE returns the old value.

## Timing
- Each SAR bit takes SETTLE_CYC+1 cycles.
- Per comparator: 1 (LOAD) + DAC_BITS·(SETTLE_CYC+1) + 1 (STORE) cycles.
- Total from the start edge to the done pulse: N_CMP·(DAC_BITS·(SETTLE_CYC+1)+2) + 1 cycles.
  - Defaults: 15·34+1 = 511 cycles.
- busy rises the cycle after start is accepted and falls when DONE is entered.
- busy and done are never high together.
- DAC_ctl changes only on LOAD, TRIAL sample edges and DONE/abort. It is stable during every settle window.
- valid[i] rises the cycle after STORE for comparator i.

## Test plan
- Bench model: cmp_out[i] = (DAC_ctl ≥ T_i).
- Default parameters, T_i = 0x8000 for all i; pulse start → done after 511 cycles; every rd_data = 0x7FFF; valid = all ones.
- T_i = 0x0000 (cmp_out always 1) for i=0 and cmp_out always 0 for i=1 → result[0]=0x0000, result[1]=0xFFFF.
- T_i = 0x1234+i·0x0101 → result[i] = T_i−1 for all 15 comparators; b_left/b_right = 4'b1111 while busy, 0 after done.
- Assert abort in TRIAL of comparator 5 → IDLE next cycle; DAC_ctl=0; valid=0x001F; no done pulse. A following start clears valid and reruns fully.
- Pulse start while busy → ignored; total latency is unchanged. Assert rst_n low mid-run → all outputs 0 asynchronously; rd_data for every address reads 0.
- SETTLE_CYC=0, DAC_BITS=8, N_CMP=4 → latency 4·10+1 = 41 cycles; rd_addr=4 → rd_data=0.
